// File: rtl/cam_match_array.sv
// cam_match_array: keyed entry storage with valid bits, flush sequencer and registered match-line output
module cam_match_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = (1 << ADDR_WIDTH),
    parameter int KEY_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  flush_req,
    input  logic                  search_en,
    input  logic [KEY_WIDTH-1:0]  search_key,
    output logic                  busy,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_lines,
    output logic [ADDR_WIDTH:0]   valid_count
);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t                state;
    logic [KEY_WIDTH-1:0]  keys [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [ADDR_WIDTH-1:0] flush_cnt;
    logic [DEPTH-1:0]      match_comb;
    logic                  idle_ok, do_wr, do_inv, do_search, wr_inc, inv_dec, flush_dec;
    assign idle_ok   = (state == IDLE) && !flush_req;
    assign do_wr     = idle_ok && wr_en;
    assign do_inv    = idle_ok && inv_en && !(wr_en && wr_addr == inv_addr);
    assign do_search = idle_ok && search_en;
    assign wr_inc    = do_wr && !valid[wr_addr];
    assign inv_dec   = do_inv && valid[inv_addr];
    assign flush_dec = (state == FLUSH) && valid[flush_cnt];
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match_comb[i] = valid[i] && (keys[i] == search_key);
    end
    always_ff @(posedge clk) begin
        if (do_wr) keys[wr_addr] <= wr_key;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            valid       <= '0;
            flush_cnt   <= '0;
            match_valid <= 1'b0;
            match_lines <= '0;
            valid_count <= '0;
        end else begin
            match_valid <= do_search;
            if (do_search) match_lines <= match_comb;
            if (state == IDLE) begin
                if (flush_req) begin
                    state     <= FLUSH;
                    busy      <= 1'b1;
                    flush_cnt <= '0;
                end else begin
                    if (do_inv) valid[inv_addr] <= 1'b0;
                    if (do_wr) valid[wr_addr] <= 1'b1;
                    valid_count <= valid_count + (ADDR_WIDTH+1)'(wr_inc) - (ADDR_WIDTH+1)'(inv_dec);
                end
            end else begin
                valid[flush_cnt] <= 1'b0;
                valid_count      <= valid_count - (ADDR_WIDTH+1)'(flush_dec);
                flush_cnt        <= flush_cnt + 1'b1;
                if (flush_cnt == ADDR_WIDTH'(DEPTH-1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_match_array.sv
// tb_cam_match_array: directed checks of write/invalidate/search/flush/reset behaviour
module tb_cam_match_array;
    logic       clk = 1'b0, reset = 1'b1;
    logic       wr_en = 1'b0, inv_en = 1'b0, flush_req = 1'b0, search_en = 1'b0;
    logic [2:0] wr_addr = '0, inv_addr = '0;
    logic [7:0] wr_key = '0, search_key = '0;
    logic       busy, match_valid;
    logic [7:0] match_lines;
    logic [3:0] valid_count;
    int         n_checks = 0, n_fail = 0;
    cam_match_array #(.ADDR_WIDTH(3), .DEPTH(8), .KEY_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
        .inv_en(inv_en), .inv_addr(inv_addr), .flush_req(flush_req), .search_en(search_en),
        .search_key(search_key), .busy(busy), .match_valid(match_valid),
        .match_lines(match_lines), .valid_count(valid_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0; inv_en = 1'b0; flush_req = 1'b0; search_en = 1'b0;
    endtask
    task automatic wr(input logic [2:0] a, input logic [7:0] k);
        wr_en = 1'b1; wr_addr = a; wr_key = k;
    endtask
    task automatic srch(input logic [7:0] k);
        search_en = 1'b1; search_key = k;
    endtask
    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mv", match_valid, 0);
        chk("rst_ml", match_lines, 0);
        chk("rst_cnt", valid_count, 0);
        @(posedge clk); #1 reset = 1'b0;
        wr(2, 8'hA5); tick();
        wr(6, 8'hA5); tick();
        srch(8'hA5); tick();
        chk("multi_mv", match_valid, 1);
        chk("multi_ml", match_lines, 8'h44);
        chk("multi_cnt", valid_count, 2);
        wr(3, 8'h11); srch(8'h11); tick();
        chk("rbw_mv", match_valid, 1);
        chk("rbw_ml", match_lines, 8'h00);
        chk("rbw_cnt", valid_count, 3);
        srch(8'h11); tick();
        chk("after_wr_ml", match_lines, 8'h08);
        wr(5, 8'h22); inv_en = 1'b1; inv_addr = 3'd6; tick();
        chk("wrinv_cnt", valid_count, 3);
        chk("idle_mv", match_valid, 0);
        chk("hold_ml", match_lines, 8'h08);
        srch(8'hA5); tick();
        chk("after_inv_ml", match_lines, 8'h04);
        wr(4, 8'h55); inv_en = 1'b1; inv_addr = 3'd4; tick();
        chk("same_addr_cnt", valid_count, 4);
        srch(8'h55); tick();
        chk("same_addr_ml", match_lines, 8'h10);
        srch(8'h22); inv_en = 1'b1; inv_addr = 3'd5; tick();
        chk("inv_same_cyc_ml", match_lines, 8'h20);
        chk("inv_cnt", valid_count, 3);
        for (int i = 0; i < 8; i++) begin
            wr(i[2:0], 8'h99); tick();
        end
        chk("fill_cnt", valid_count, 8);
        srch(8'h99); tick();
        chk("fill_ml", match_lines, 8'hFF);
        flush_req = 1'b1; tick();
        chk("flush_busy0", busy, 1);
        for (int i = 1; i < 8; i++) begin
            wr(0, 8'h99); srch(8'h99); tick();
            chk("flush_busy", busy, 1);
            chk("flush_mv", match_valid, 0);
        end
        wr(0, 8'h99); srch(8'h99); tick();
        chk("flush_end_busy", busy, 0);
        chk("flush_end_mv", match_valid, 0);
        chk("flush_end_cnt", valid_count, 0);
        srch(8'h99); tick();
        chk("post_flush_mv", match_valid, 1);
        chk("post_flush_ml", match_lines, 8'h00);
        chk("post_flush_cnt", valid_count, 0);
        wr(1, 8'h33); tick();
        srch(8'h33); tick();
        chk("pre_abort_ml", match_lines, 8'h02);
        flush_req = 1'b1; tick();
        tick(); tick(); tick();
        chk("mid_flush_busy", busy, 1);
        #3 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", valid_count, 0);
        chk("abort_ml", match_lines, 0);
        @(posedge clk); #1 reset = 1'b0;
        wr(1, 8'h33); tick();
        chk("recover_cnt", valid_count, 1);
        srch(8'h33); tick();
        chk("recover_ml", match_lines, 8'h02);
        wr(1, 8'h44); tick();
        chk("overwrite_cnt", valid_count, 1);
        srch(8'h33); tick();
        chk("old_key_ml", match_lines, 8'h00);
        srch(8'h44); tick();
        chk("new_key_ml", match_lines, 8'h02);
        chk("new_key_mv", match_valid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_match_array.md
Name: cam_match_array

Overview:
- Key-storage and match-line generator for the CAM datapath.
- Holds DEPTH keys with per-entry valid bits and supports write, invalidate and flush maintenance.
- On a search, produces a registered DEPTH-bit match vector that feeds the cam priority encoder's cam_data_in.
- Mirror block of the encoder: it produces match lines, and the encoder consumes them.

Parameters:
ADDR_WIDTH, 8, entry address width
DEPTH, (1 << ADDR_WIDTH), number of entries; equals the match vector width
KEY_WIDTH, 16, stored/search key width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request: store wr_key at wr_addr and set valid
wr_addr  input  ADDR_WIDTH  write entry index
wr_key  input  KEY_WIDTH  key to store
inv_en  input  1  invalidate request: clear valid of entry inv_addr
inv_addr  input  ADDR_WIDTH  invalidate entry index
flush_req  input  1  start sequential clear of all valid bits
search_en  input  1  search request
search_key  input  KEY_WIDTH  key to compare
busy  output  1  high while flush in progress; all requests ignored
match_valid  output  1  one-cycle pulse: match_lines valid
match_lines  output  DEPTH  bit i = entry i valid and key equal
valid_count  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (async, immediate): all valid bits 0, state IDLE, busy 0, match_valid 0, match_lines 0, valid_count 0, flush counter 0. Key storage not reset.
- FSM states IDLE and FLUSH. Requests are sampled only in IDLE; in FLUSH, wr_en, inv_en, search_en and flush_req are dropped with no effect.
- Priority in IDLE:
  - flush_req wins over everything: a same-cycle wr/inv/search is dropped.
  - Otherwise wr, inv and search are processed in the same cycle.
- Write: at the edge, key[wr_addr] <= wr_key and valid[wr_addr] <= 1. Overwriting a valid entry leaves the count unchanged; writing an invalid entry increments it.
- Invalidate: valid[inv_addr] <= 0. Decrements the count only if the entry was valid.
- wr_en and inv_en at the same address: write wins, entry ends valid, count changes as for the write alone.
- Different addresses: both take effect; count change is the net of the two.
- Search (1-cycle latency):
  - search_en sampled at edge N gives match_valid=1 and match_lines registered after edge N, i.e. valid during cycle N+1.
  - Compare uses storage state before edge N (read-before-write): a same-cycle write is not visible; a same-cycle invalidate still matches.
  - Multiple matches are all set; no priority is applied here.
  - match_valid is 0 in cycles without a search. match_lines holds its last value when match_valid=0 and is cleared by reset only.
- Flush:
  - flush_req in IDLE moves to FLUSH with counter=0; busy=1 from the next cycle.
  - Each FLUSH cycle clears valid[counter] (count decremented if it was set), then the counter increments.
  - After clearing entry DEPTH-1: counter wraps to 0, state returns to IDLE, busy=0 the following cycle.
  - Flush therefore occupies exactly DEPTH cycles of busy; valid_count is 0 on exit.
- Reset asserted mid-flush aborts it: IDLE, all valid cleared.
- valid_count never exceeds DEPTH and never underflows; width ADDR_WIDTH+1 holds DEPTH exactly.

Test Plan (ADDR_WIDTH=3, DEPTH=8, KEY_WIDTH=8):
- After reset, write 0xA5 to addr 2 and 0xA5 to addr 6, then search 0xA5 -> next cycle match_valid=1, match_lines=8'b0100_0100, valid_count=2.
- Write 0x11 to addr 3 with search 0x11 in the same cycle -> match_lines=8'h00 (read-before-write); repeat search next cycle -> 8'h08.
- With addr 6 valid, assert wr_en at addr 5 (key 0x22) and inv_en at addr 6 together -> valid_count unchanged at 3; search 0xA5 -> 8'h04. Then wr_en + inv_en both at addr 4 -> entry 4 valid, count 4.
- Fill all 8 entries, then flush_req -> busy high exactly 8 cycles, wr_en and search_en during busy ignored (match_valid stays 0), valid_count 0 after; search any key -> 8'h00.
- Assert reset 3 cycles into a flush -> busy=0, valid_count=0, match_lines=0 immediately (asynchronously); next write/search works normally.
- Overwrite a valid addr 1 key 0x33 with 0x44 -> valid_count unchanged; search 0x33 -> 8'h00, search 0x44 -> 8'h02.
